muldiv_alu: RTL and testbench

MULDIV_ALU -- requirements
Module: muldiv_alu

---
 rtl/muldiv_alu.sv | 285 ++++++++++++++++++++++++++++
 tb/tb_muldiv_alu.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_alu.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_alu
// Purpose  : Registered integer ALU with HI/LO registers; the optional
//            iterative multiply/divide engine is enabled by MULDIV_ALU_MULDIV_EN.
// Revision : 1.0  initial release
// ============================================================================
module muldiv_alu #(
   parameter int NB_REG      = 32,
   parameter int NB_ALU_CTRL = 5
) (
   input  logic                   i_clk,
   input  logic                   i_reset,
   input  logic                   i_valid,
   output logic                   o_ready,
   input  logic [NB_ALU_CTRL-1:0] i_alu_ctrl,
   input  logic [NB_REG-1:0]      i_a,
   input  logic [NB_REG-1:0]      i_b,
   output logic                   o_valid,
   output logic [NB_REG-1:0]      o_result,
   output logic                   o_zero,
   output logic                   o_oe,
   output logic                   o_illegal
);

   localparam int C_NB_SH = $clog2(NB_REG);

   localparam logic [NB_ALU_CTRL-1:0] C_OP_SLL   = NB_ALU_CTRL'(32'h00);
   localparam logic [NB_ALU_CTRL-1:0] C_OP_SRL   = NB_ALU_CTRL'(32'h01);
   localparam logic [NB_ALU_CTRL-1:0] C_OP_SRA   = NB_ALU_CTRL'(32'h02);
   localparam logic [NB_ALU_CTRL-1:0] C_OP_ADD   = NB_ALU_CTRL'(32'h03);
   localparam logic [NB_ALU_CTRL-1:0] C_OP_SUB   = NB_ALU_CTRL'(32'h04);
   localparam logic [NB_ALU_CTRL-1:0] C_OP_AND   = NB_ALU_CTRL'(32'h05);
   localparam logic [NB_ALU_CTRL-1:0] C_OP_OR    = NB_ALU_CTRL'(32'h06);
   localparam logic [NB_ALU_CTRL-1:0] C_OP_XOR   = NB_ALU_CTRL'(32'h07);
   localparam logic [NB_ALU_CTRL-1:0] C_OP_NOR   = NB_ALU_CTRL'(32'h08);
   localparam logic [NB_ALU_CTRL-1:0] C_OP_SLT   = NB_ALU_CTRL'(32'h09);
   localparam logic [NB_ALU_CTRL-1:0] C_OP_SLL16 = NB_ALU_CTRL'(32'h0A);
   localparam logic [NB_ALU_CTRL-1:0] C_OP_EQ    = NB_ALU_CTRL'(32'h0B);
   localparam logic [NB_ALU_CTRL-1:0] C_OP_NEQ   = NB_ALU_CTRL'(32'h0C);
   localparam logic [NB_ALU_CTRL-1:0] C_OP_SLTU  = NB_ALU_CTRL'(32'h0D);
   localparam logic [NB_ALU_CTRL-1:0] C_OP_MFHI  = NB_ALU_CTRL'(32'h14);
   localparam logic [NB_ALU_CTRL-1:0] C_OP_MFLO  = NB_ALU_CTRL'(32'h15);
   localparam logic [NB_ALU_CTRL-1:0] C_OP_MTHI  = NB_ALU_CTRL'(32'h16);
   localparam logic [NB_ALU_CTRL-1:0] C_OP_MTLO  = NB_ALU_CTRL'(32'h17);

   logic                   w_accept;
   logic                   w_is_md;
   logic                   w_wb;
   logic [NB_REG-1:0]      w_wb_hi;
   logic [NB_REG-1:0]      w_wb_lo;

   logic                   r_cap_vld;
   logic [NB_ALU_CTRL-1:0] r_op;
   logic [NB_REG-1:0]      r_a;
   logic [NB_REG-1:0]      r_b;
   logic [NB_REG-1:0]      r_hi;
   logic [NB_REG-1:0]      r_lo;

   logic [C_NB_SH-1:0]     w_shamt;
   logic [NB_REG-1:0]      w_sum;
   logic [NB_REG-1:0]      w_diff;
   logic [NB_REG-1:0]      w_res;
   logic                   w_oe;
   logic                   w_ill;

   assign w_accept = i_valid & o_ready;

   // Single-cycle requests are captured here; the result registers one edge later.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_cap_vld <= 1'b0;
         r_op      <= '0;
         r_a       <= '0;
         r_b       <= '0;
      end else begin
         r_cap_vld <= w_accept & ~w_is_md;
         if (w_accept & ~w_is_md) begin
            r_op <= i_alu_ctrl;
            r_a  <= i_a;
            r_b  <= i_b;
         end
      end
   end

   assign w_shamt = r_a[C_NB_SH-1:0];
   assign w_sum   = r_a + r_b;
   assign w_diff  = r_a - r_b;

   always_comb begin
      w_res = '0;
      w_oe  = 1'b0;
      w_ill = 1'b0;
      case (r_op)
         C_OP_SLL:   w_res = r_b << w_shamt;
         C_OP_SRL:   w_res = r_b >> w_shamt;
         C_OP_SRA:   w_res = $signed(r_b) >>> w_shamt;
         C_OP_ADD: begin
            w_res = w_sum;
            w_oe  = (r_a[NB_REG-1] == r_b[NB_REG-1]) && (w_sum[NB_REG-1] != r_a[NB_REG-1]);
         end
         C_OP_SUB: begin
            w_res = w_diff;
            w_oe  = (r_a[NB_REG-1] != r_b[NB_REG-1]) && (w_diff[NB_REG-1] != r_a[NB_REG-1]);
         end
         C_OP_AND:   w_res = r_a & r_b;
         C_OP_OR:    w_res = r_a | r_b;
         C_OP_XOR:   w_res = r_a ^ r_b;
         C_OP_NOR:   w_res = ~(r_a | r_b);
         C_OP_SLT:   w_res = {{(NB_REG-1){1'b0}}, ($signed(r_a) < $signed(r_b))};
         C_OP_SLL16: w_res = r_b << (NB_REG/2);
         C_OP_EQ:    w_res = {{(NB_REG-1){1'b0}}, (r_a == r_b)};
         C_OP_NEQ:   w_res = {{(NB_REG-1){1'b0}}, (r_a != r_b)};
         C_OP_SLTU:  w_res = {{(NB_REG-1){1'b0}}, (r_a < r_b)};
         C_OP_MFHI:  w_res = r_hi;
         C_OP_MFLO:  w_res = r_lo;
         C_OP_MTHI:  w_res = '0;
         C_OP_MTLO:  w_res = '0;
         default:    w_ill = 1'b1;
      endcase
   end

   // Flags only change on a completion so they hold between results.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         o_valid   <= 1'b0;
         o_result  <= '0;
         o_zero    <= 1'b0;
         o_oe      <= 1'b0;
         o_illegal <= 1'b0;
         r_hi      <= '0;
         r_lo      <= '0;
      end else begin
         o_valid <= r_cap_vld | w_wb;
         if (w_wb) begin
            o_result  <= '0;
            o_zero    <= 1'b1;
            o_oe      <= 1'b0;
            o_illegal <= 1'b0;
            r_hi      <= w_wb_hi;
            r_lo      <= w_wb_lo;
         end else if (r_cap_vld) begin
            o_result  <= w_res;
            o_zero    <= (w_res == '0);
            o_oe      <= w_oe;
            o_illegal <= w_ill;
            if (r_op == C_OP_MTHI) r_hi <= r_a;
            if (r_op == C_OP_MTLO) r_lo <= r_a;
         end
      end
   end

`ifdef MULDIV_ALU_MULDIV_EN
   localparam logic [NB_ALU_CTRL-1:0] C_OP_MULT  = NB_ALU_CTRL'(32'h10);
   localparam logic [NB_ALU_CTRL-1:0] C_OP_MULTU = NB_ALU_CTRL'(32'h11);
   localparam logic [NB_ALU_CTRL-1:0] C_OP_DIV   = NB_ALU_CTRL'(32'h12);
   localparam logic [NB_ALU_CTRL-1:0] C_OP_DIVU  = NB_ALU_CTRL'(32'h13);

   localparam logic [1:0] C_ST_IDLE = 2'd0;
   localparam logic [1:0] C_ST_MUL  = 2'd1;
   localparam logic [1:0] C_ST_DIV  = 2'd2;
   localparam logic [1:0] C_ST_DONE = 2'd3;

   localparam logic [C_NB_SH-1:0] C_CNT_LAST = C_NB_SH'(NB_REG-1);

   logic [1:0]          r_state;
   logic [1:0]          w_state_nxt;
   logic                w_iter;
   logic                w_fix;
   logic [C_NB_SH-1:0]  r_cnt;
   logic [NB_REG-1:0]   r_acc_hi;
   logic [NB_REG-1:0]   r_acc_lo;
   logic [NB_REG-1:0]   r_opnd;
   logic                r_is_div;
   logic                r_neg_q;
   logic                r_neg_r;
   logic                r_wb;

   logic                w_sa;
   logic                w_sb;
   logic [NB_REG-1:0]   w_abs_a;
   logic [NB_REG-1:0]   w_abs_b;
   logic [NB_REG:0]     w_msum;
   logic [NB_REG:0]     w_drem;
   logic                w_dge;
   logic [NB_REG-1:0]   w_dsub;
   logic [2*NB_REG-1:0] w_prod_neg;

   assign w_is_md = (i_alu_ctrl == C_OP_MULT) || (i_alu_ctrl == C_OP_MULTU) ||
                    (i_alu_ctrl == C_OP_DIV)  || (i_alu_ctrl == C_OP_DIVU);

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) r_state <= C_ST_IDLE;
      else         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         C_ST_IDLE: if (w_accept && w_is_md) w_state_nxt = i_alu_ctrl[1] ? C_ST_DIV : C_ST_MUL;
         C_ST_MUL,
         C_ST_DIV:  if (r_cnt == C_CNT_LAST) w_state_nxt = C_ST_DONE;
         C_ST_DONE: w_state_nxt = C_ST_IDLE;
         default:   w_state_nxt = C_ST_IDLE;
      endcase
   end

   always_comb begin
      o_ready = (r_state == C_ST_IDLE);
      w_iter  = (r_state == C_ST_MUL) || (r_state == C_ST_DIV);
      w_fix   = (r_state == C_ST_DONE);
   end

   // Both engines run on magnitudes; signs are applied in DONE.
   assign w_sa    = ~i_alu_ctrl[0] & i_a[NB_REG-1];
   assign w_sb    = ~i_alu_ctrl[0] & i_b[NB_REG-1];
   assign w_abs_a = w_sa ? (~i_a + 1'b1) : i_a;
   assign w_abs_b = w_sb ? (~i_b + 1'b1) : i_b;

   assign w_msum     = {1'b0, r_acc_hi} + (r_acc_lo[0] ? {1'b0, r_opnd} : '0);
   assign w_drem     = {r_acc_hi, r_acc_lo[NB_REG-1]};
   assign w_dge      = (w_drem >= {1'b0, r_opnd});
   assign w_dsub     = w_drem[NB_REG-1:0] - r_opnd;
   assign w_prod_neg = ~{r_acc_hi, r_acc_lo} + 1'b1;

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_cnt    <= '0;
         r_acc_hi <= '0;
         r_acc_lo <= '0;
         r_opnd   <= '0;
         r_is_div <= 1'b0;
         r_neg_q  <= 1'b0;
         r_neg_r  <= 1'b0;
         r_wb     <= 1'b0;
      end else begin
         r_wb <= w_fix;
         if (w_accept && w_is_md) begin
            r_cnt    <= '0;
            r_acc_hi <= '0;
            r_is_div <= i_alu_ctrl[1];
            r_neg_r  <= w_sa;
            if (i_alu_ctrl[1]) begin
               r_acc_lo <= w_abs_a;
               r_opnd   <= w_abs_b;
               // Division by zero keeps the all-ones quotient unsigned.
               r_neg_q  <= (w_sa ^ w_sb) & (|i_b);
            end else begin
               r_acc_lo <= w_abs_b;
               r_opnd   <= w_abs_a;
               r_neg_q  <= w_sa ^ w_sb;
            end
         end else if (w_iter) begin
            r_cnt <= r_cnt + 1'b1;
            if (r_is_div) begin
               r_acc_hi <= w_dge ? w_dsub : w_drem[NB_REG-1:0];
               r_acc_lo <= {r_acc_lo[NB_REG-2:0], w_dge};
            end else begin
               r_acc_hi <= w_msum[NB_REG:1];
               r_acc_lo <= {w_msum[0], r_acc_lo[NB_REG-1:1]};
            end
         end else if (w_fix) begin
            if (r_is_div) begin
               if (r_neg_q) r_acc_lo <= ~r_acc_lo + 1'b1;
               if (r_neg_r) r_acc_hi <= ~r_acc_hi + 1'b1;
            end else if (r_neg_q) begin
               {r_acc_hi, r_acc_lo} <= w_prod_neg;
            end
         end
      end
   end

   assign w_wb    = r_wb;
   assign w_wb_hi = r_acc_hi;
   assign w_wb_lo = r_acc_lo;
`else
   assign w_is_md = 1'b0;
   assign o_ready = 1'b1;
   assign w_wb    = 1'b0;
   assign w_wb_hi = '0;
   assign w_wb_lo = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_muldiv_alu.sv
`default_nettype none
// ============================================================================
// Module   : tb_muldiv_alu
// Purpose  : Directed self-checking bench for muldiv_alu (both build options).
// Revision : 1.0  initial release
// ============================================================================
module tb_muldiv_alu;

   localparam logic [4:0] C_SLL = 5'h00, C_SRL = 5'h01, C_SRA = 5'h02, C_ADD = 5'h03;
   localparam logic [4:0] C_SUB = 5'h04, C_AND = 5'h05, C_OR = 5'h06, C_XOR = 5'h07;
   localparam logic [4:0] C_NOR = 5'h08, C_SLT = 5'h09, C_SLL16 = 5'h0A, C_EQ = 5'h0B;
   localparam logic [4:0] C_NEQ = 5'h0C, C_SLTU = 5'h0D, C_MULT = 5'h10, C_MULTU = 5'h11;
   localparam logic [4:0] C_DIV = 5'h12, C_DIVU = 5'h13, C_MFHI = 5'h14, C_MFLO = 5'h15;
   localparam logic [4:0] C_MTHI = 5'h16, C_MTLO = 5'h17;

   logic        clk;
   logic        i_reset;
   logic        i_valid;
   logic        o_ready;
   logic [4:0]  i_alu_ctrl;
   logic [31:0] i_a;
   logic [31:0] i_b;
   logic        o_valid;
   logic [31:0] o_result;
   logic        o_zero;
   logic        o_oe;
   logic        o_illegal;

   int n_vec  = 0;
   int n_miss = 0;

   muldiv_alu #(.NB_REG(32), .NB_ALU_CTRL(5)) dut (
      .i_clk      (clk),
      .i_reset    (i_reset),
      .i_valid    (i_valid),
      .o_ready    (o_ready),
      .i_alu_ctrl (i_alu_ctrl),
      .i_a        (i_a),
      .i_b        (i_b),
      .o_valid    (o_valid),
      .o_result   (o_result),
      .o_zero     (o_zero),
      .o_oe       (o_oe),
      .o_illegal  (o_illegal)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_miss++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Drive one request so it is accepted at the next rising edge; returns 1 time unit later.
   task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      i_valid = 1'b1; i_alu_ctrl = op; i_a = a; i_b = b;
      @(posedge clk); #1;
      i_valid = 1'b0;
   endtask

   task automatic run1(input string tag, input logic [4:0] op, input logic [31:0] a,
                       input logic [31:0] b);
      issue(op, a, b);
      chk({tag, ".early"}, {31'd0, o_valid}, 32'd0);
      @(posedge clk); #1;
   endtask

   task automatic expect_out(input string tag, input logic [31:0] res, input logic zero,
                             input logic oe, input logic ill);
      chk({tag, ".valid"}, {31'd0, o_valid},   32'd1);
      chk({tag, ".res"},   o_result,           res);
      chk({tag, ".zero"},  {31'd0, o_zero},    {31'd0, zero});
      chk({tag, ".oe"},    {31'd0, o_oe},      {31'd0, oe});
      chk({tag, ".ill"},   {31'd0, o_illegal}, {31'd0, ill});
   endtask

   task automatic md_wait(input string tag);
      int lowc;
      int vedge;
      logic [31:0] rv;
      logic zv;
      lowc = 0; vedge = -1; rv = 32'hDEADBEEF; zv = 1'b0;
      for (int k = 0; k < 60; k++) begin
         if (!o_ready) lowc++;
         if (o_valid && vedge < 0) begin vedge = k; rv = o_result; zv = o_zero; end
         @(posedge clk); #1;
      end
      chk({tag, ".busy"},  lowc,  32'd33);
      chk({tag, ".vedge"}, vedge, 32'd34);
      chk({tag, ".res"},   rv,    32'd0);
      chk({tag, ".zero"},  {31'd0, zv}, 32'd1);
   endtask

   logic [31:0] exp_hi;
   logic [31:0] exp_lo;
   int          vcnt;

   initial begin
      i_reset = 1'b1; i_valid = 1'b0; i_alu_ctrl = '0; i_a = '0; i_b = '0;
      #12;
      chk("rst.ready",  {31'd0, o_ready},   32'd1);
      chk("rst.valid",  {31'd0, o_valid},   32'd0);
      chk("rst.result", o_result,           32'd0);
      chk("rst.flags",  {29'd0, o_zero, o_oe, o_illegal}, 32'd0);
      @(negedge clk); i_reset = 1'b0;

      run1("add_ovf", C_ADD, 32'h7FFF_FFFF, 32'h0000_0001);
      expect_out("add_ovf", 32'h8000_0000, 1'b0, 1'b1, 1'b0);
      run1("sub_ovf", C_SUB, 32'h8000_0000, 32'h0000_0001);
      expect_out("sub_ovf", 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0);
      run1("and", C_AND, 32'hF0F0_F0F0, 32'hFF00_FF00);
      expect_out("and", 32'hF000_F000, 1'b0, 1'b0, 1'b0);
      run1("or",  C_OR,  32'hF0F0_F0F0, 32'hFF00_FF00);
      expect_out("or",  32'hFFF0_FFF0, 1'b0, 1'b0, 1'b0);
      run1("xor", C_XOR, 32'hF0F0_F0F0, 32'hFF00_FF00);
      expect_out("xor", 32'h0FF0_0FF0, 1'b0, 1'b0, 1'b0);
      run1("nor", C_NOR, 32'hF0F0_F0F0, 32'hFF00_FF00);
      expect_out("nor", 32'h000F_000F, 1'b0, 1'b0, 1'b0);
      run1("sll_hi_ignored", C_SLL, 32'h0000_0024, 32'h0000_0001);
      expect_out("sll_hi_ignored", 32'h0000_0010, 1'b0, 1'b0, 1'b0);
      run1("srl", C_SRL, 32'h0000_0004, 32'h8000_0000);
      expect_out("srl", 32'h0800_0000, 1'b0, 1'b0, 1'b0);
      run1("slt", C_SLT, 32'hFFFF_FFFF, 32'h0000_0001);
      expect_out("slt", 32'h0000_0001, 1'b0, 1'b0, 1'b0);
      run1("sltu", C_SLTU, 32'hFFFF_FFFF, 32'h0000_0001);
      expect_out("sltu", 32'h0000_0000, 1'b1, 1'b0, 1'b0);
      run1("sll16", C_SLL16, 32'h0000_0000, 32'h0000_1234);
      expect_out("sll16", 32'h1234_0000, 1'b0, 1'b0, 1'b0);
      run1("eq", C_EQ, 32'd5, 32'd5);
      expect_out("eq", 32'h0000_0001, 1'b0, 1'b0, 1'b0);
      run1("neq", C_NEQ, 32'd5, 32'd5);
      expect_out("neq", 32'h0000_0000, 1'b1, 1'b0, 1'b0);

      run1("mthi", C_MTHI, 32'hAAAA_5555, 32'h0);
      expect_out("mthi", 32'h0, 1'b1, 1'b0, 1'b0);
      run1("mtlo", C_MTLO, 32'h1234_5678, 32'h0);
      run1("mfhi", C_MFHI, 32'h0, 32'h0);
      expect_out("mfhi", 32'hAAAA_5555, 1'b0, 1'b0, 1'b0);
      run1("mflo", C_MFLO, 32'h0, 32'h0);
      expect_out("mflo", 32'h1234_5678, 1'b0, 1'b0, 1'b0);
      exp_hi = 32'hAAAA_5555; exp_lo = 32'h1234_5678;

      // Illegal opcode and SRA issued on consecutive edges.
      @(negedge clk);
      i_valid = 1'b1; i_alu_ctrl = 5'h1F; i_a = 32'h1; i_b = 32'h1;
      @(posedge clk); #1;
      chk("b2b.ready", {31'd0, o_ready}, 32'd1);
      i_alu_ctrl = C_SRA; i_a = 32'h0000_0004; i_b = 32'h8000_0000;
      @(posedge clk); #1;
      i_valid = 1'b0;
      expect_out("b2b.ill", 32'h0, 1'b1, 1'b0, 1'b1);
      @(posedge clk); #1;
      expect_out("b2b.sra", 32'hF800_0000, 1'b0, 1'b0, 1'b0);

`ifdef MULDIV_ALU_MULDIV_EN
      issue(C_MULT, 32'hFFFF_FFFD, 32'h0000_0005);
      md_wait("mult");
      run1("mult.hi", C_MFHI, 32'h0, 32'h0);
      expect_out("mult.hi", 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
      run1("mult.lo", C_MFLO, 32'h0, 32'h0);
      expect_out("mult.lo", 32'hFFFF_FFF1, 1'b0, 1'b0, 1'b0);

      issue(C_DIV, 32'hFFFF_FFF9, 32'h0000_0002);
      md_wait("div");
      run1("div.lo", C_MFLO, 32'h0, 32'h0);
      expect_out("div.lo", 32'hFFFF_FFFD, 1'b0, 1'b0, 1'b0);
      run1("div.hi", C_MFHI, 32'h0, 32'h0);
      expect_out("div.hi", 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);

      issue(C_DIVU, 32'h0000_0009, 32'h0000_0000);
      md_wait("divu0");
      run1("divu0.lo", C_MFLO, 32'h0, 32'h0);
      expect_out("divu0.lo", 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
      run1("divu0.hi", C_MFHI, 32'h0, 32'h0);
      expect_out("divu0.hi", 32'h0000_0009, 1'b0, 1'b0, 1'b0);
      exp_hi = 32'h0000_0009; exp_lo = 32'hFFFF_FFFF;
`else
      issue(C_MULT, 32'hFFFF_FFFD, 32'h0000_0005);
      chk("mult_off.ready", {31'd0, o_ready}, 32'd1);
      @(posedge clk); #1;
      expect_out("mult_off", 32'h0, 1'b1, 1'b0, 1'b1);
      chk("mult_off.ready2", {31'd0, o_ready}, 32'd1);
      run1("divu_off", C_DIVU, 32'd9, 32'd0);
      expect_out("divu_off", 32'h0, 1'b1, 1'b0, 1'b1);
`endif
      run1("ill0e", 5'h0E, 32'h1, 32'h1);
      expect_out("ill0e", 32'h0, 1'b1, 1'b0, 1'b1);
      run1("keep.hi", C_MFHI, 32'h0, 32'h0);
      expect_out("keep.hi", exp_hi, (exp_hi == 32'h0), 1'b0, 1'b0);
      run1("keep.lo", C_MFLO, 32'h0, 32'h0);
      expect_out("keep.lo", exp_lo, (exp_lo == 32'h0), 1'b0, 1'b0);

`ifdef MULDIV_ALU_MULDIV_EN
      // Reset lands mid-iteration of MULTU; no completion may leak out.
      issue(C_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      repeat (10) @(posedge clk);
      @(negedge clk); i_reset = 1'b1;
      #1;
      chk("abort.ready",  {31'd0, o_ready}, 32'd1);
      chk("abort.valid",  {31'd0, o_valid}, 32'd0);
      chk("abort.result", o_result,         32'd0);
      @(negedge clk);
      i_reset = 1'b0;
      i_valid = 1'b1; i_alu_ctrl = C_SUB; i_a = 32'd5; i_b = 32'd5;
      @(posedge clk); #1;
      i_valid = 1'b0;
      @(posedge clk); #1;
      expect_out("abort.sub", 32'h0, 1'b1, 1'b0, 1'b0);
      vcnt = 0;
      for (int k = 0; k < 40; k++) begin
         @(posedge clk); #1;
         if (o_valid) vcnt++;
      end
      chk("abort.novalid", vcnt, 32'd0);
      run1("abort.hi", C_MFHI, 32'h0, 32'h0);
      expect_out("abort.hi", 32'h0, 1'b1, 1'b0, 1'b0);
      run1("abort.lo", C_MFLO, 32'h0, 32'h0);
      expect_out("abort.lo", 32'h0, 1'b1, 1'b0, 1'b0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
`default_nettype wire
